// File: rtl/if_id_req_initiator.sv
// FIFO-buffered initiator of the four-phase req/ack handshake toward the ID stage.
// Define IF_REQ_TIMEOUT_EN to build the REQ_HI abandon timer (TIMEOUT_CYC cycles).
module if_id_req_initiator #(
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned PC_W        = 8,
    parameter int unsigned DEPTH       = 4,
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [DATA_W-1:0]      in_instr,
    input  logic [PC_W-1:0]        in_pc,
    input  logic                   flush,
    output logic                   req,
    input  logic                   ack,
    output logic [DATA_W-1:0]      instr_out,
    output logic [PC_W-1:0]        pc_out,
    output logic                   busy,
    output logic [$clog2(DEPTH):0] count,
    output logic                   proto_err,
    output logic                   timeout
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned ENT_W = DATA_W + PC_W;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("DEPTH must be a power of 2 and at least 2");
    end
    if (TIMEOUT_CYC < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYC must be at least 1");
    end

    typedef enum logic [1:0] {IDLE, REQ_HI, REQ_LO} state_e;

    state_e             state_q, state_d;
    logic [ENT_W-1:0]   mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               req_q, req_d;
    logic [DATA_W-1:0]  instr_q, instr_d;
    logic [PC_W-1:0]    pc_q, pc_d;
    logic               proto_err_q, proto_err_d;
    logic               ack_meta_q, ack_s_q;
    logic               push_c, pop_c;

`ifdef IF_REQ_TIMEOUT_EN
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYC + 1);
    logic [TMO_W-1:0]   tmo_cnt_q, tmo_cnt_d;
    logic               timeout_q, timeout_d;
`endif

    assign in_ready  = (count_q < CNT_W'(DEPTH)) && !flush;
    assign push_c    = in_valid && in_ready;
    assign req       = req_q;
    assign instr_out = instr_q;
    assign pc_out    = pc_q;
    assign busy      = (state_q != IDLE);
    assign count     = count_q;
    assign proto_err = proto_err_q;

    // ack crosses in from ID's domain through two flops
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ack_meta_q <= 1'b0;
            ack_s_q    <= 1'b0;
        end else begin
            ack_meta_q <= ack;
            ack_s_q    <= ack_meta_q;
        end
    end

    always_ff @(posedge clk) begin
        if (push_c) mem_q[wr_ptr_q] <= {in_instr, in_pc};
    end

    // Handshake FSM: issue from IDLE, wait for ack_s high, then for ack_s low
    always_comb begin
        state_d     = state_q;
        req_d       = req_q;
        instr_d     = instr_q;
        pc_d        = pc_q;
        proto_err_d = proto_err_q;
        pop_c       = 1'b0;
`ifdef IF_REQ_TIMEOUT_EN
        timeout_d   = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (ack_s_q) proto_err_d = 1'b1;
                if (count_q != '0 && !flush) begin
                    {instr_d, pc_d} = mem_q[rd_ptr_q];
                    pop_c           = 1'b1;
                    req_d           = 1'b1;
                    state_d         = REQ_HI;
                end
            end
            REQ_HI: begin
                if (ack_s_q) begin
                    req_d   = 1'b0;
                    state_d = REQ_LO;
                end
`ifdef IF_REQ_TIMEOUT_EN
                else if (tmo_cnt_q == TMO_W'(TIMEOUT_CYC - 1)) begin
                    req_d     = 1'b0;
                    timeout_d = 1'b1;
                    state_d   = REQ_LO;
                end
`endif
            end
            REQ_LO: begin
                if (!ack_s_q) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // FIFO bookkeeping; flush wins over a same-cycle push
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_c) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop_c)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            if (push_c && !pop_c)      count_d = count_q + CNT_W'(1);
            else if (!push_c && pop_c) count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            req_q       <= 1'b0;
            instr_q     <= '0;
            pc_q        <= '0;
            proto_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            req_q       <= req_d;
            instr_q     <= instr_d;
            pc_q        <= pc_d;
            proto_err_q <= proto_err_d;
        end
    end

`ifdef IF_REQ_TIMEOUT_EN
    // Counter is zero outside REQ_HI, so it restarts on every entry
    always_comb begin
        tmo_cnt_d = '0;
        if (state_q == REQ_HI) tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tmo_cnt_q <= '0;
            timeout_q <= 1'b0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout = timeout_q;
`else
    assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_if_id_req_initiator.sv
// Randomized self-checking bench for if_id_req_initiator against a queue-based reference model.
module tb_if_id_req_initiator;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned PC_W   = 8;
    localparam int unsigned DEPTH  = 4;
    localparam int unsigned TCYC   = 8;
    localparam int unsigned CNT_W  = $clog2(DEPTH) + 1;
    localparam int unsigned VW     = 5 + CNT_W + DATA_W + PC_W;
`ifdef IF_REQ_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst, in_valid, in_ready, flush, req, ack, busy, proto_err, timeout;
    logic [DATA_W-1:0] in_instr, instr_out;
    logic [PC_W-1:0]   in_pc, pc_out;
    logic [CNT_W-1:0]  count;

    if_id_req_initiator #(
        .DATA_W(DATA_W), .PC_W(PC_W), .DEPTH(DEPTH), .TIMEOUT_CYC(TCYC)
    ) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .flush(flush), .req(req), .ack(ack),
        .instr_out(instr_out), .pc_out(pc_out), .busy(busy), .count(count),
        .proto_err(proto_err), .timeout(timeout)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    // Reference model: queue of buffered entries plus handshake phase (0 idle, 1 req high, 2 req low)
    logic [DATA_W+PC_W-1:0] mq[$];
    logic [PC_W-1:0]        issued[$];
    int                     m_phase, m_hi;
    logic                   m_proto, m_tmo, a1, a2, last_push;
    logic [DATA_W-1:0]      m_instr;
    logic [PC_W-1:0]        m_pc;

    // ID responder: mode 0 holds ack low, 1 answers after resp_dly cycles, 2 drives ack_force
    int   resp_mode, resp_dly, rc;
    logic ack_force;
    bit   rand_dly;

    function automatic logic [VW-1:0] obs_vec();
        return {req, busy, count, proto_err, timeout, in_ready, instr_out, pc_out};
    endfunction

    function automatic logic [VW-1:0] exp_vec();
        return {m_phase == 1, m_phase != 0, CNT_W'(mq.size()), m_proto, m_tmo,
                (mq.size() < int'(DEPTH)) && !flush, m_instr, m_pc};
    endfunction

    task automatic model_reset();
        mq.delete();
        m_phase = 0; m_hi = 0; m_proto = 1'b0; m_tmo = 1'b0;
        a1 = 1'b0; a2 = 1'b0; m_instr = '0; m_pc = '0; last_push = 1'b0;
    endtask

    task automatic step();
        logic pv, pf, ms;
        logic [DATA_W+PC_W-1:0] word;
        if (resp_mode == 2) ack = ack_force;
        else if (resp_mode == 0) begin ack = 1'b0; rc = 0; end
        else if (req && !ack) begin
            if (rc >= resp_dly) begin ack = 1'b1; rc = 0; if (rand_dly) resp_dly = $urandom_range(0, 6); end
            else rc++;
        end else if (!req && ack) begin
            if (rc >= resp_dly) begin ack = 1'b0; rc = 0; if (rand_dly) resp_dly = $urandom_range(0, 6); end
            else rc++;
        end else rc = 0;
        pv   = in_valid && (mq.size() < int'(DEPTH)) && !flush;
        pf   = flush;
        ms   = a2;
        word = {in_instr, in_pc};
        @(posedge clk);
        m_tmo = 1'b0;
        case (m_phase)
            0: begin
                if (ms) m_proto = 1'b1;
                if (mq.size() > 0 && !pf) begin
                    {m_instr, m_pc} = mq.pop_front();
                    issued.push_back(m_pc);
                    m_phase = 1;
                    m_hi    = 0;
                end
            end
            1: begin
                m_hi++;
                if (ms) m_phase = 2;
                else if (TMO_EN && m_hi == int'(TCYC)) begin m_phase = 2; m_tmo = 1'b1; end
            end
            default: if (!ms) m_phase = 0;
        endcase
        if (pf) mq.delete();
        else if (pv) mq.push_back(word);
        a2 = a1;
        a1 = ack;
        last_push = pv;
        cyc++;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b0; in_valid = 1'b0; flush = 1'b0; ack = 1'b0; ack_force = 1'b0;
        in_instr = '0; in_pc = '0; resp_mode = 0; resp_dly = 3; rc = 0; rand_dly = 0;
        model_reset();
        repeat (2) @(negedge clk);
        checks++;
        if (obs_vec() !== exp_vec()) begin
            failures++;
            $display("FAIL reset_state got=%h exp=%h", obs_vec(), exp_vec());
        end
        rst = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            checks++;
            if (obs_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL reset_idle cyc=%0d got=%h exp=%h", cyc, obs_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_single();
        resp_mode = 1; resp_dly = 3;
        in_valid = 1'b1; in_instr = 32'hDEADBEEF; in_pc = 8'h10;
        step();
        in_valid = 1'b0;
        step();
        checks++;
        if (req !== 1'b1 || instr_out !== 32'hDEADBEEF || pc_out !== 8'h10) begin
            failures++;
            $display("FAIL single_latency got req=%b instr=%h pc=%h exp req=1 instr=deadbeef pc=10", req, instr_out, pc_out);
        end
        for (int i = 0; i < 25; i++) begin
            step();
            checks++;
            if (obs_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL single cyc=%0d got=%h exp=%h", cyc, obs_vec(), exp_vec());
            end
        end
        checks++;
        if (busy !== 1'b0 || instr_out !== 32'hDEADBEEF || pc_out !== 8'h10) begin
            failures++;
            $display("FAIL single_done got busy=%b instr=%h pc=%h exp busy=0 instr=deadbeef pc=10", busy, instr_out, pc_out);
        end
    endtask

    task automatic test_back_to_back();
        int  waited, max_cnt, base;
        bit  full_seen;
        max_cnt = 0; full_seen = 0; base = issued.size();
        resp_mode = 0;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; in_instr = $urandom; in_pc = PC_W'(i * 4); waited = 0;
            do begin
                step();
                checks++;
                if (obs_vec() !== exp_vec()) begin
                    failures++;
                    $display("FAIL b2b cyc=%0d got=%h exp=%h", cyc, obs_vec(), exp_vec());
                end
                if (int'(count) > max_cnt) max_cnt = int'(count);
                if (count == CNT_W'(DEPTH) && !in_ready) full_seen = 1;
                waited++;
                if (waited > 6) resp_mode = 1;
            end while (!last_push && waited < 60);
            if (!last_push) begin
                failures++;
                $display("FAIL b2b_accept entry=%0d not accepted within 60 cycles", i);
            end
        end
        in_valid = 1'b0; resp_mode = 1;
        for (int i = 0; i < 80; i++) begin
            step();
            checks++;
            if (obs_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL b2b_drain cyc=%0d got=%h exp=%h", cyc, obs_vec(), exp_vec());
            end
        end
        checks++;
        if (max_cnt != int'(DEPTH) || !full_seen) begin
            failures++;
            $display("FAIL b2b_full got max_count=%0d full_seen=%0d exp max_count=%0d full_seen=1", max_cnt, full_seen, DEPTH);
        end
        checks++;
        if (issued.size() - base != 5) begin
            failures++;
            $display("FAIL b2b_issues got=%0d exp=5", issued.size() - base);
        end else begin
            for (int k = 0; k < 5; k++) begin
                checks++;
                if (issued[base + k] !== PC_W'(k * 4)) begin
                    failures++;
                    $display("FAIL b2b_order idx=%0d got=%h exp=%h", k, issued[base + k], PC_W'(k * 4));
                end
            end
        end
    endtask

    task automatic test_flush();
        int base;
        base = issued.size();
        resp_mode = 1; resp_dly = 8;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_instr = $urandom; in_pc = PC_W'($urandom);
            step();
            checks++;
            if (obs_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL flush_fill cyc=%0d got=%h exp=%h", cyc, obs_vec(), exp_vec());
            end
        end
        flush = 1'b1; in_valid = 1'b1; in_instr = $urandom; in_pc = 8'hEE;
        step();
        flush = 1'b0; in_valid = 1'b0;
        checks++;
        if (count !== '0 || req !== 1'b1) begin
            failures++;
            $display("FAIL flush_clear got count=%0d req=%b exp count=0 req=1", count, req);
        end
        for (int i = 0; i < 40; i++) begin
            step();
            checks++;
            if (obs_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL flush_after cyc=%0d got=%h exp=%h", cyc, obs_vec(), exp_vec());
            end
        end
        checks++;
        if (issued.size() - base != 1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL flush_issues got issues=%0d busy=%b exp issues=1 busy=0", issued.size() - base, busy);
        end
    endtask

    task automatic test_proto_err();
        resp_mode = 2; ack_force = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (i == 4) ack_force = 1'b0;
            step();
            checks++;
            if (obs_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL proto cyc=%0d got=%h exp=%h", cyc, obs_vec(), exp_vec());
            end
        end
        checks++;
        if (proto_err !== 1'b1 || req !== 1'b0) begin
            failures++;
            $display("FAIL proto_sticky got proto_err=%b req=%b exp proto_err=1 req=0", proto_err, req);
        end
        resp_mode = 1;
    endtask

    task automatic test_random();
        resp_mode = 1; rand_dly = 1;
        for (int i = 0; i < 600; i++) begin
            in_valid = ($urandom_range(0, 2) != 0);
            in_instr = $urandom;
            in_pc    = PC_W'($urandom);
            flush    = ($urandom_range(0, 19) == 0);
            step();
            checks++;
            if (obs_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL random cyc=%0d got=%h exp=%h", cyc, obs_vec(), exp_vec());
            end
        end
        in_valid = 1'b0; flush = 1'b0; rand_dly = 0; resp_dly = 2;
        for (int i = 0; i < 80; i++) begin
            step();
            checks++;
            if (obs_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL random_drain cyc=%0d got=%h exp=%h", cyc, obs_vec(), exp_vec());
            end
        end
    endtask

`ifdef IF_REQ_TIMEOUT_EN
    task automatic test_timeout();
        int pulses, base;
        pulses = 0; base = issued.size();
        resp_mode = 0;
        for (int i = 0; i < 40; i++) begin
            in_valid = (i < 2); in_instr = $urandom; in_pc = PC_W'(8'hA0 + i);
            step();
            checks++;
            if (obs_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL timeout cyc=%0d got=%h exp=%h", cyc, obs_vec(), exp_vec());
            end
            if (timeout) pulses++;
        end
        checks++;
        if (pulses != 2 || issued.size() - base != 2 || busy !== 1'b0) begin
            failures++;
            $display("FAIL timeout_summary got pulses=%0d issues=%0d busy=%b exp pulses=2 issues=2 busy=0", pulses, issued.size() - base, busy);
        end
        resp_mode = 1;
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_flush();
        test_proto_err();
`ifdef IF_REQ_TIMEOUT_EN
        test_timeout();
`endif
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/if_id_req_initiator.md
Name: if_id_req_initiator

Overview:
- Initiator (sending) end of the four-phase req/ack handshake that the ID stage consumes.
- Sits between instruction fetch and ID. Buffers fetched {instr, pc} pairs in a small FIFO and presents each one to ID with req.
- Holds data stable until ack completes the return-to-zero cycle.
- Supports branch flush of buffered, not-yet-issued entries.

Parameters:
- DATA_W, 32: instruction width.
- PC_W, 8: PC width.
- DEPTH, 4: FIFO entries. Must be a power of 2 and ≥2.
- TIMEOUT_CYC, 255: cycles req may stay high without ack. Used only with IF_REQ_TIMEOUT_EN.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  fetch offers an entry.
- in_ready  out  1  FIFO can accept an entry.
- in_instr  in  DATA_W  fetched instruction.
- in_pc  in  PC_W  PC of the fetched instruction.
- flush  in  1  branch taken; discard buffered entries.
- req  out  1  handshake request to ID.
- ack  in  1  handshake acknowledge from ID; may be asynchronous to clk.
- instr_out  out  DATA_W  instruction presented to ID.
- pc_out  out  PC_W  PC presented to ID.
- busy  out  1  handshake in progress (state != IDLE).
- count  out  $clog2(DEPTH)+1  current FIFO occupancy.
- proto_err  out  1  sticky: ack rose while idle.
- timeout  out  1  one-cycle pulse when a req is abandoned.

Behaviour:
- Reset (rst=0, asynchronous):
  - req=0, instr_out=0, pc_out=0, count=0.
  - Read and write pointers = 0; state=IDLE.
  - Synchronizer flops = 0; proto_err=0; timeout=0.
- ack synchronizer:
  - ack passes through a 2-flop synchronizer to give ack_s.
  - All FSM decisions use ack_s. This adds 2 cycles of ack latency.
- FIFO:
  - in_ready = (count < DEPTH) && !flush. This is combinational, so in_ready=1 right after reset.
  - Push occurs when in_valid && in_ready.
  - Pointers wrap modulo DEPTH.
  - Push and pop in the same cycle leave count unchanged.
  - A push while full is impossible because in_ready=0.
- FSM states IDLE, REQ_HI, REQ_LO:
  - IDLE: if count>0, load head into instr_out/pc_out, pop, set req<=1, go to REQ_HI. Otherwise hold.
  - REQ_HI: req=1; instr_out/pc_out are held stable. When ack_s=1, set req<=0 and go to REQ_LO.
  - REQ_LO: req=0. When ack_s=0, go to IDLE.
  - The next issue happens no earlier than the cycle after IDLE is re-entered.
- Latency:
  - An entry pushed at edge N into an empty FIFO while IDLE gives req=1 after edge N+1.
  - instr_out/pc_out change only on the edge that raises req.
  - instr_out/pc_out keep their last value while idle.
- Flush:
  - Clears count and both pointers on that edge. Flush takes priority over a simultaneous push; that entry is dropped.
  - An in-flight transfer (REQ_HI or REQ_LO) is not aborted. It completes the full four-phase cycle, because dropping req without ack would break the protocol.
  - A flush in IDLE while count>0 prevents the issue in that cycle.
- proto_err: set when ack_s=1 while state is IDLE. Cleared only by reset. The event is otherwise ignored.
- count never exceeds DEPTH and never underflows.

Optional Feature:
- Macro IF_REQ_TIMEOUT_EN.
- Defined:
  - A counter runs while in REQ_HI and clears on entry to REQ_HI.
  - If it reaches TIMEOUT_CYC with ack_s still 0: req<=0, timeout pulses high for 1 cycle, state goes to REQ_LO.
  - The abandoned entry is not retried.
- Undefined: no counter is built, timeout is tied to 0, and REQ_HI waits indefinitely.

Test Plan:
- Reset then idle → req=0, count=0, in_ready=1, proto_err=0. Hold 10 cycles with no change.
- Push instr=0xDEADBEEF, pc=0x10 at edge N; ID model acks 3 cycles after req rises and drops ack 3 cycles after req falls.
  - Required: req=1 after N+1; instr_out=0xDEADBEEF and pc_out=0x10 held stable until req falls.
  - Required: busy=0 after ack_s falls.
- Push 5 entries back-to-back with DEPTH=4 and ack stalled low.
  - Required: first entry issues; count reaches 4 and in_ready=0.
  - Required: the 5th is accepted only after the first pop; all issue in order with pcs 0x00, 0x04, 0x08, 0x0C, 0x10.
- Fill 3 entries and assert flush during REQ_HI of entry 0 with in_valid=1 the same cycle.
  - Required: count=0 next cycle; the same-cycle push is dropped; entry 0 completes its handshake.
  - Required: no further req until new pushes.
- Pulse ack high for 4 cycles while IDLE → proto_err=1 and stays 1; no req is raised.
- IF_REQ_TIMEOUT_EN with TIMEOUT_CYC=8, ack held 0 → req falls 8 cycles after rising, timeout pulses for one cycle, state returns to IDLE, and the next entry issues.
